// File: rtl/disc_leaky_relu_stage.sv
// LeakyReLU activation stage between discriminator layers 1 and 2.
// Captures a whole Q8.8 vector on start, then activates one element per clock through one shared multiplier.
module disc_leaky_relu_stage #(
    parameter int                 N_ELEMS   = 128,
    parameter logic signed [15:0] ALPHA_Q88 = 16'sd51,
    parameter int                 CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [16*N_ELEMS-1:0]  flat_input_flat,
    output logic [16*N_ELEMS-1:0]  flat_output_flat,
    output logic [CNT_W-1:0]       neg_count,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q,    state_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [CNT_W-1:0]      runCnt_q,   runCnt_d;
    logic [CNT_W-1:0]      negCount_q, negCount_d;
    logic                  done_q,     done_d;
    logic [16*N_ELEMS-1:0] capBuf_q,   capBuf_d;
    logic [16*N_ELEMS-1:0] flatOut_q,  flatOut_d;

    logic signed [15:0]    xSel;
    logic signed [31:0]    prod;
    logic [15:0]           yVal;
    logic                  isNeg;
    logic                  unusedProdBits;

    // Only bits [23:8] of the product are kept: arithmetic >>8 truncating toward -inf.
    assign xSel           = capBuf_q[{idx_q, 4'b0000} +: 16];
    assign isNeg          = xSel[15];
    assign prod           = 32'(xSel) * 32'(ALPHA_Q88);
    assign yVal           = isNeg ? prod[23:8] : xSel;
    assign unusedProdBits = ^{prod[31:24], prod[7:0]};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        runCnt_d   = runCnt_q;
        negCount_d = negCount_q;
        done_d     = 1'b0;
        capBuf_d   = capBuf_q;
        flatOut_d  = flatOut_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capBuf_d = flat_input_flat;
                    idx_d    = '0;
                    runCnt_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                flatOut_d[{idx_q, 4'b0000} +: 16] = yVal;
                idx_d    = idx_q + IDX_W'(1);
                runCnt_d = runCnt_q + CNT_W'(isNeg);
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    idx_d      = '0;
                    negCount_d = runCnt_q + CNT_W'(isNeg);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            runCnt_q   <= '0;
            negCount_q <= '0;
            done_q     <= 1'b0;
            capBuf_q   <= '0;
            flatOut_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            runCnt_q   <= runCnt_d;
            negCount_q <= negCount_d;
            done_q     <= done_d;
            capBuf_q   <= capBuf_d;
            flatOut_q  <= flatOut_d;
        end
    end

    assign flat_output_flat = flatOut_q;
    assign neg_count        = negCount_q;
    assign busy             = (state_q == ST_RUN);
    assign done             = done_q;

endmodule

// File: tb/tb_disc_leaky_relu_stage.sv
// Directed, table-driven bench for disc_leaky_relu_stage.
module tb_disc_leaky_relu_stage;

    localparam int N     = 128;
    localparam int CNT_W = 8;
    localparam int W     = 16 * N;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   flatIn;
    logic [W-1:0]   flatOut;
    logic [CNT_W-1:0] negCount;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    disc_leaky_relu_stage #(.N_ELEMS(N), .ALPHA_Q88(16'sd51), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .flat_input_flat(flatIn),
        .flat_output_flat(flatOut),
        .neg_count(negCount),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Counts elements differing from a uniform expected value; one comparison.
    task automatic checkUniform(input string name, input logic [15:0] exp);
        int diffs = 0;
        for (int i = 0; i < N; i++)
            if (flatOut[16*i +: 16] !== exp) diffs++;
        checkOutput(name, 32'(diffs), 32'd0);
    endtask

    // Drives a vector with a one-cycle start pulse; returns #1 after the sampling edge.
    task automatic applyStimulus(input logic [W-1:0] vec);
        flatIn = vec;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles, output int busyCnt);
        cycles  = 0;
        busyCnt = busy ? 1 : 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) return;
            if (busy) busyCnt++;
        end
        cycles = -1;
    endtask

    function automatic logic [W-1:0] fillVec(input logic [15:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    initial begin
        vec_t table_[12];
        logic [W-1:0] vec;
        int cycles, busyCnt, doneCnt, doneAt, diffs;
        logic sawDone;

        table_[0]  = '{16'hFF00, 16'hFFCD};
        table_[1]  = '{16'hFFFF, 16'hFFFF};
        table_[2]  = '{16'h8000, 16'hE680};
        table_[3]  = '{16'h7FFF, 16'h7FFF};
        table_[4]  = '{16'h0000, 16'h0000};
        table_[5]  = '{16'h0100, 16'h0100};
        table_[6]  = '{16'hFE00, 16'hFF9A};
        table_[7]  = '{16'h0001, 16'h0001};
        table_[8]  = '{16'hFFFE, 16'hFFFF};
        table_[9]  = '{16'hFF01, 16'hFFCD};
        table_[10] = '{16'hC000, 16'hF340};
        table_[11] = '{16'hFF80, 16'hFFE6};

        rst    = 1'b1;
        start  = 1'b0;
        flatIn = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and quiet idle period.
        sawDone = 1'b0;
        diffs   = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
            if (flatOut !== '0 || negCount !== '0 || busy !== 1'b0) diffs++;
        end
        checkOutput("idleOutputsZero", 32'(diffs), 32'd0);
        checkOutput("idleNoDone", 32'(sawDone), 32'd0);

        // All +1.0: latency, busy duration, single-cycle done.
        applyStimulus(fillVec(16'h0100));
        waitDone(300, cycles, busyCnt);
        checkOutput("onesLatency", 32'(cycles), 32'd128);
        checkOutput("onesBusyCycles", 32'(busyCnt), 32'd128);
        checkUniform("onesOutputs", 16'h0100);
        checkOutput("onesNegCount", 32'(negCount), 32'd0);
        checkOutput("onesBusyAtDone", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("onesDonePulse", 32'(done), 32'd0);

        // Corner-value table at the low elements, zeros elsewhere.
        vec = '0;
        for (int i = 0; i < 12; i++) vec[16*i +: 16] = table_[i].x;
        @(negedge clk);
        applyStimulus(vec);
        waitDone(300, cycles, busyCnt);
        checkOutput("tableLatency", 32'(cycles), 32'd128);
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("tableElem%0d", i), 32'(flatOut[16*i +: 16]), 32'(table_[i].y));
        diffs = 0;
        for (int i = 12; i < N; i++)
            if (flatOut[16*i +: 16] !== 16'h0000) diffs++;
        checkOutput("tableZeroTail", 32'(diffs), 32'd0);
        checkOutput("tableNegCount", 32'(negCount), 32'd8);

        // Restarts while busy and a bus change after capture must be ignored.
        @(negedge clk);
        applyStimulus(fillVec(16'hFF00));
        doneCnt = 0;
        doneAt  = 0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 1) flatIn = fillVec(16'h0100);
            start = (c == 5 || c == 60);
            @(posedge clk);
            #1;
            if (done) begin
                doneCnt++;
                doneAt = c;
            end
        end
        start = 1'b0;
        checkOutput("ignoreDoneCount", 32'(doneCnt), 32'd1);
        checkOutput("ignoreDoneAt", 32'(doneAt), 32'd128);
        checkUniform("ignoreOutputs", 16'hFFCD);
        checkOutput("ignoreNegCount", 32'(negCount), 32'd128);

        // Reset mid-run aborts with no done, then a fresh run.
        @(negedge clk);
        applyStimulus(fillVec(16'h0100));
        sawDone = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == 70) rst = 1'b1;
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abortFlatZero", 32'(flatOut !== '0), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortNegCount", 32'(negCount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abortNoDone", 32'(sawDone), 32'd0);
        @(negedge clk);
        applyStimulus(fillVec(16'hFE00));
        waitDone(300, cycles, busyCnt);
        checkOutput("afterAbortLatency", 32'(cycles), 32'd128);
        checkUniform("afterAbortOutputs", 16'hFF9A);
        checkOutput("afterAbortNegCount", 32'(negCount), 32'd128);

        // Back-to-back: second start issued in the done cycle.
        vec = fillVec(16'h0100);
        for (int i = 0; i < 10; i++) vec[16*i +: 16] = 16'hFF00;
        @(negedge clk);
        applyStimulus(vec);
        waitDone(300, cycles, busyCnt);
        checkOutput("b2bFirstLatency", 32'(cycles), 32'd128);
        checkOutput("b2bFirstNegCount", 32'(negCount), 32'd10);
        applyStimulus(fillVec(16'h0200));
        checkOutput("b2bAccepted", 32'(busy), 32'd1);
        for (int c = 1; c < 64; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("b2bNegHeld", 32'(negCount), 32'd10);
        checkOutput("b2bNewElem0", 32'(flatOut[15:0]), 32'h0200);
        checkOutput("b2bOldElem100", 32'(flatOut[16*100 +: 16]), 32'h0100);
        waitDone(300, cycles, busyCnt);
        checkOutput("b2bSecondRemaining", 32'(cycles), 32'd65);
        checkUniform("b2bSecondOutputs", 16'h0200);
        checkOutput("b2bSecondNegCount", 32'(negCount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disc_leaky_relu_stage.md
Name: disc_leaky_relu_stage

Overview:
- Activation stage directly downstream of discriminator layer 1.
- Consumes the 128-element Q8.8 pre-activation vector that layer 1 presents on its output bus when it pulses done.
- Applies LeakyReLU element by element, one element per clock, through a single shared multiplier.
- Presents the activated vector, plus a count of negative inputs, to discriminator layer 2.

Parameters:
- N_ELEMS, 128, number of 16-bit elements in the vector.
- ALPHA_Q88, 16'sd51, negative-slope coefficient in signed Q8.8 (51/256 ≈ 0.2); must be ≥ 0.
- CNT_W, 8, width of neg_count; must satisfy 2^CNT_W > N_ELEMS.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to process the vector on flat_input_flat; normally driven by layer 1 done.
- flat_input_flat  input  16*N_ELEMS  signed Q8.8 vector; element k is at bits [16k+15:16k].
- flat_output_flat  output  16*N_ELEMS  signed Q8.8 activated vector, registered, same packing as the input.
- neg_count  output  CNT_W  number of input elements < 0 in the last completed run.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when flat_output_flat and neg_count are complete.

Behaviour:
- Reset (rst=1 at a clock edge):
  - flat_output_flat=0, neg_count=0, busy=0, done=0.
  - Internal index=0, state=IDLE.
  - Reset during a run aborts it; no done is issued and partial results are discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN:
  - Taken at edge E0 when start=1 and busy=0.
  - At E0: copy the whole flat_input_flat into an internal capture buffer, set index=0, clear the running negative counter, set busy<=1.
  - The input bus may change after E0 without affecting the run.
- RUN:
  - At edge E(k+1), k = 0..N_ELEMS-1, element k is computed from the capture buffer and written to flat_output_flat[16k+15:16k].
  - Index increments by 1; the running counter increments if x<0.
  - Elements not yet written keep their values from the previous run.
- RUN -> IDLE:
  - Taken at the edge that writes element N_ELEMS-1 (E_N).
  - At E_N: busy<=0, done<=1, neg_count<=final count (including element N_ELEMS-1).
  - done is high for exactly the one cycle after E_N; latency from start sampled to done asserted is N_ELEMS cycles.
- Arithmetic, per element x (signed 16):
  - x ≥ 0: y = x, bit-exact (including 0x7FFF).
  - x < 0: p = x * ALPHA_Q88 as a signed 32-bit product; y = p[23:8]. This is an arithmetic shift right by 8, truncating toward −inf, with no rounding.
  - No saturation is needed while ALPHA_Q88 ≤ 256. With ALPHA_Q88 = 256, y = x.
- start while busy=1 is ignored; no queuing and no restart.
- start may be accepted in the cycle where done is high, because busy is already 0 then. That start begins a new run at the next edge; flat_output_flat holds the old results until overwritten element by element.
- neg_count changes only at E_N and holds between runs.
- flat_output_flat is guaranteed complete only from the done cycle until the next accepted start plus 1 edge.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0; done never asserts.
- All 128 inputs = 0x0100 (+1.0), pulse start -> done exactly 128 cycles after start is sampled; every output 0x0100; neg_count=0; busy high for exactly 128 cycles.
- Corner values:
  - input[0] = 0xFF00 (−1.0) -> 0xFFCD (−51).
  - input[1] = 0xFFFF (−1) -> 0xFFFF (floor of −51/256).
  - input[2] = 0x8000 -> 0xE680 (−32768*51>>8 = −6528).
  - input[3] = 0x7FFF -> 0x7FFF.
  - Remaining elements 0 -> 0.
  - neg_count = 3.
- Start pulsed again at cycles 5 and 60 of a run, and the input bus changed 1 cycle after start -> no effect; results match the values captured at the accepted start; exactly one done.
- rst asserted at cycle 70 of a run, then a new start with all inputs 0xFE00 -> no done from the aborted run; new run yields every output 0xFF9A (−512*51>>8 = −102) and neg_count=128.
- Back-to-back runs with start asserted in the done cycle -> second run is accepted; its done comes 128 cycles later; neg_count updates only at each done.
